// File: rtl/bsearch_pkg.sv
// bsearch_pkg: shared types and helpers for the binary-search engine.
//   state_t    : engine FSM states
//   mode_t     : search mode (exact match / lower bound)
//   MAX_PROBES : upper bound on RAM probes per search for an ADDR_W-bit array
package bsearch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        COMPARE,
        DONE
    } state_t;

    typedef enum logic {
        MODE_EXACT  = 1'b0,
        MODE_LBOUND = 1'b1
    } mode_t;

    // Halving a range of 2**addr_w entries down to empty takes at most addr_w+1 probes.
    function automatic int MAX_PROBES(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/bsearch_cycle_counter.sv
// bsearch_cycle_counter: saturating latency counter for the search engine.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : restart the running count at 0
//   inc          : count this cycle (saturates at all-ones)
//   cap          : copy the count, including this cycle's increment, to cycles
//   cycles       : captured latency of the last completed search
module bsearch_cycle_counter
    import bsearch_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             cap,
    output logic [CNT_W-1:0] cycles
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt;
        if (clr) begin
            cnt_next = '0;
        end else if (inc && (cnt != '1)) begin
            cnt_next = cnt + 1'b1;
        end
    end

    // Capturing cnt_next lets cycles appear together with done and still
    // include the final COMPARE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            cycles <= '0;
        end else begin
            cnt <= cnt_next;
            if (cap) begin
                cycles <= cnt_next;
            end
        end
    end

endmodule

// File: rtl/bsearch_engine.sv
// bsearch_engine: binary search over a sorted synchronous-read RAM.
// Modes: exact match (mode=0) or lower bound, first entry >= key (mode=1).
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   start         : request pulse, accepted only in IDLE (key/mode latched)
//   key, mode     : search key and mode
//   mem_addr      : RAM read address (registered, held while waiting)
//   mem_rdata     : RAM read data, valid RAM_LAT cycles after mem_addr
//   busy          : high from the cycle after accept until DONE is left
//   done          : one-cycle result strobe
//   found, loc    : result flag and index, held until the next done
//   cycles        : ISSUE/WAIT/COMPARE cycles of the last search (saturating)
// Build option: define BSEARCH_CYCLES_EN to include the latency counter;
// otherwise cycles is tied to 0.
module bsearch_engine
    import bsearch_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 5,
    parameter int RAM_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] key,
    input  logic              mode,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] loc,
    output logic [CNT_W-1:0]  cycles
);

    localparam logic [ADDR_W:0] DEPTH       = {1'b1, {ADDR_W{1'b0}}};
    localparam int              WAIT_W      = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(RAM_LAT - 1);
    localparam logic [ADDR_W:0] PROBE_LIMIT = (ADDR_W + 1)'(MAX_PROBES(ADDR_W));

    state_t              state;
    logic [DATA_W-1:0]   key_q;
    mode_t               mode_q;
    logic [ADDR_W:0]     lo;
    logic [ADDR_W:0]     hi;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [ADDR_W:0]     probe_cnt;

    logic [ADDR_W-1:0]   mid;
    logic [ADDR_W:0]     lo_nx;
    logic [ADDR_W:0]     hi_nx;
    logic                hit;
    logic                closed;

    // lo < hi <= DEPTH keeps the midpoint below DEPTH, so truncation is lossless.
    assign mid = ADDR_W'(({1'b0, lo} + {1'b0, hi}) >> 1);

    always_comb begin
        lo_nx = lo;
        hi_nx = hi;
        if (mem_rdata < key_q) begin
            lo_nx = {1'b0, mid} + 1'b1;
        end else begin
            hi_nx = {1'b0, mid};
        end
        hit    = (mode_q == MODE_EXACT) && (mem_rdata == key_q);
        closed = (lo_nx == hi_nx);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            key_q     <= '0;
            mode_q    <= MODE_EXACT;
            lo        <= '0;
            hi        <= '0;
            wait_cnt  <= '0;
            probe_cnt <= '0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
            loc       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_q     <= key;
                        mode_q    <= mode_t'(mode);
                        lo        <= '0;
                        hi        <= DEPTH;
                        probe_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_addr  <= mid;
                    wait_cnt  <= '0;
                    probe_cnt <= probe_cnt + 1'b1;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        state <= COMPARE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        found <= 1'b1;
                        loc   <= mid;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        lo <= lo_nx;
                        hi <= hi_nx;
                        if (closed) begin
                            if (mode_q == MODE_EXACT) begin
                                found <= 1'b0;
                                loc   <= '0;
                            end else begin
                                // lo == DEPTH means key exceeds every entry; low bits are then 0.
                                found <= ~lo_nx[ADDR_W];
                                loc   <= lo_nx[ADDR_W-1:0];
                            end
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BSEARCH_CYCLES_EN
    logic cnt_clr;
    logic cnt_inc;
    logic cnt_cap;

    assign cnt_clr = (state == IDLE) && start;
    assign cnt_inc = (state == ISSUE) || (state == WAIT) || (state == COMPARE);
    assign cnt_cap = (state == COMPARE) && (hit || closed);

    bsearch_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .cap     (cnt_cap),
        .cycles  (cycles)
    );
`else
    assign cycles = '0;
`endif

    a_probe_bound: assert property (@(posedge clk) disable iff (!reset_n)
        (state == ISSUE) |-> (probe_cnt < PROBE_LIMIT));

endmodule

// File: tb/tb_bsearch_engine.sv
`timescale 1ns/1ps
module tb_bsearch_engine;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 8;
    localparam int LAT0   = 1;
    localparam int LAT1   = 3;

    typedef struct {
        int f;
        int l;
        int c;
    } exp_t;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b0;
    logic              start   = 1'b0;
    logic              mode    = 1'b0;
    logic [DATA_W-1:0] key     = '0;

    logic [ADDR_W-1:0] mem_addr [2];
    logic [DATA_W-1:0] mem_rdata[2];
    logic              busy     [2];
    logic              done     [2];
    logic              found    [2];
    logic [ADDR_W-1:0] loc      [2];
    logic [CNT_W-1:0]  cycles   [2];
    logic [DATA_W-1:0] pipe0, pipe1;

    exp_t        res_q  [2][$];
    int unsigned probe_q[2][$];
    int unsigned pl[$];
    int          idx[2];
    logic        busy_chk[2];
    int          n_vec  = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    bsearch_engine #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .RAM_LAT (LAT0), .CNT_W (CNT_W)
    ) u_dut0 (
        .clk (clk), .reset_n (reset_n), .start (start), .key (key), .mode (mode),
        .mem_addr (mem_addr[0]), .mem_rdata (mem_rdata[0]), .busy (busy[0]),
        .done (done[0]), .found (found[0]), .loc (loc[0]), .cycles (cycles[0])
    );

    bsearch_engine #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .RAM_LAT (LAT1), .CNT_W (CNT_W)
    ) u_dut1 (
        .clk (clk), .reset_n (reset_n), .start (start), .key (key), .mode (mode),
        .mem_addr (mem_addr[1]), .mem_rdata (mem_rdata[1]), .busy (busy[1]),
        .done (done[1]), .found (found[1]), .loc (loc[1]), .cycles (cycles[1])
    );

    // Sorted RAM contents: mem[i] = 4*i + 2.
    function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
        return DATA_W'(4 * int'(a) + 2);
    endfunction

    always @(posedge clk) begin
        mem_rdata[0] <= ram_word(mem_addr[0]);
        pipe0        <= ram_word(mem_addr[1]);
        pipe1        <= pipe0;
        mem_rdata[1] <= pipe1;
    end

    function automatic int exp_cyc(input int probes, input int lat);
`ifdef BSEARCH_CYCLES_EN
        return probes * (2 + lat);
`else
        return 0 * probes * lat;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: event occurred, none expected", name);
    endtask

    // Scoreboard monitor: results on done, busy low afterwards, probe addresses.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int per;
            per = 2 + ((d == 0) ? LAT0 : LAT1);
            if (busy_chk[d]) begin
                check($sformatf("busy_after_done[%0d]", d), int'(busy[d]), 0);
                busy_chk[d] = 1'b0;
            end
            if (done[d]) begin
                if (res_q[d].size() == 0) begin
                    flag($sformatf("unexpected_done[%0d]", d));
                end else begin
                    exp_t e;
                    e = res_q[d].pop_front();
                    check($sformatf("found[%0d]", d), int'(found[d]), e.f);
                    check($sformatf("loc[%0d]", d), int'(loc[d]), e.l);
                    check($sformatf("cycles[%0d]", d), int'(cycles[d]), e.c);
                    busy_chk[d] = 1'b1;
                end
            end
            if (busy[d]) begin
                if (idx[d] >= 1 && ((idx[d] - 1) % per) == 0) begin
                    if (probe_q[d].size() == 0) begin
                        flag($sformatf("unexpected_probe[%0d]", d));
                    end else begin
                        check($sformatf("probe_addr[%0d]", d), int'(mem_addr[d]),
                              int'(probe_q[d].pop_front()));
                    end
                end
                idx[d]++;
            end else begin
                idx[d] = 0;
            end
        end
    end

    task automatic expect_search(input int f, input int l);
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            e.f = f;
            e.l = l;
            e.c = exp_cyc(pl.size(), (d == 0) ? LAT0 : LAT1);
            res_q[d].push_back(e);
            foreach (pl[i]) probe_q[d].push_back(pl[i]);
        end
    endtask

    task automatic pulse_start(input int k, input logic m);
        @(posedge clk); #1;
        key   = DATA_W'(k);
        mode  = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        key   = ~key;
        mode  = ~mode;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while ((busy[0] || busy[1]) && t < 300);
        if (busy[0] || busy[1]) flag("wait_idle_timeout");
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_busy[%0d]", tag, d), int'(busy[d]), 0);
            check($sformatf("%s_done[%0d]", tag, d), int'(done[d]), 0);
            check($sformatf("%s_found[%0d]", tag, d), int'(found[d]), 0);
            check($sformatf("%s_loc[%0d]", tag, d), int'(loc[d]), 0);
            check($sformatf("%s_cycles[%0d]", tag, d), int'(cycles[d]), 0);
            check($sformatf("%s_addr[%0d]", tag, d), int'(mem_addr[d]), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int d = 0; d < 2; d++) begin
            idx[d]      = 0;
            busy_chk[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // 1: exact hit
        pl = '{16, 8, 12, 10};
        expect_search(1, 10);
        pulse_start(42, 1'b0);
        wait_idle();

        // 2: miss in exact mode, same key as lower bound
        pl = '{16, 8, 12, 10, 11};
        expect_search(0, 0);
        pulse_start(43, 1'b0);
        wait_idle();
        expect_search(1, 11);
        pulse_start(43, 1'b1);
        wait_idle();

        // 3: lower-bound boundaries: above all entries, below all entries
        pl = '{16, 24, 28, 30, 31};
        expect_search(0, 0);
        pulse_start(200, 1'b1);
        wait_idle();
        pl = '{16, 8, 4, 2, 1, 0};
        expect_search(1, 0);
        pulse_start(0, 1'b1);
        wait_idle();

        // 4: starts during a search and in the DONE cycle are ignored
        pl = '{16, 8, 12, 10};
        expect_search(1, 10);
        pulse_start(42, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        key   = 8'd99;
        mode  = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (!done[0] && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!done[0]) flag("done_wait_timeout");
        key   = 8'd5;
        mode  = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        repeat (30) @(posedge clk);
        #1;

        // 5: reset during WAIT of the second probe abandons the search
        pl = '{16, 24};
        for (int d = 0; d < 2; d++) foreach (pl[i]) probe_q[d].push_back(pl[i]);
        pulse_start(126, 1'b0);
        repeat (5) @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_zero("midreset");
        for (int d = 0; d < 2; d++) probe_q[d].delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        pl = '{16, 24, 28, 30, 31};
        expect_search(1, 31);
        pulse_start(126, 1'b0);
        wait_idle();
        repeat (10) @(posedge clk);
        #1;

        for (int d = 0; d < 2; d++) begin
            check($sformatf("results_pending[%0d]", d), res_q[d].size(), 0);
            check($sformatf("probes_pending[%0d]", d), probe_q[d].size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
